// File: rtl/dac_sample_pacer_if.sv
// -----------------------------------------------------------------------------
// dac_sample_pacer_if
// Groups the two data paths around the sample pacer:
//   producer side : in_data / in_valid  (producer -> pacer), in_ready (pacer -> producer)
//   DAC side      : dac_data / dac_start (pacer -> DAC driver), dac_busy (driver -> pacer)
// Modports:
//   slave  - the pacer itself (consumes samples, drives the DAC driver)
//   master - the surrounding environment (producer plus DAC driver)
// -----------------------------------------------------------------------------
interface dac_sample_pacer_if #(
    parameter int DATA_W = 12
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              dac_busy;
    logic [DATA_W-1:0] dac_data;
    logic              dac_start;

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        input  dac_busy,
        output dac_data,
        output dac_start
    );

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        output dac_busy,
        input  dac_data,
        input  dac_start
    );
endinterface

// File: rtl/dac_sample_pacer.sv
// -----------------------------------------------------------------------------
// dac_sample_pacer
// Buffers samples from a producer in a small FIFO and releases exactly one sample
// per programmable sample period towards the DAC7611P serial driver.
//
// Ports:
//   clk_50M   in   system clock
//   rst       in   synchronous reset, active-high
//   enable    in   1 = pacing runs, 0 = tick counter held at its reload value
//   period    in   clock cycles per sample (values below 2 behave as 2)
//   bus       slave modport of dac_sample_pacer_if:
//               in_data/in_valid/in_ready   producer handshake (in_ready = !full)
//               dac_data/dac_start/dac_busy  DAC driver word, 1-cycle start, busy flag
//   level     out  FIFO occupancy 0..2**DEPTH_LOG2
//   underrun  out  sticky: a tick found the FIFO empty
//   late      out  sticky: a tick found the DAC driver busy
//
// Optional feature (macro DAC_PACER_HOLD_REFRESH_EN):
//   when defined, a tick that finds the FIFO empty while the driver is idle
//   re-issues dac_start with the previous dac_data (zero-order-hold refresh).
// -----------------------------------------------------------------------------
module dac_sample_pacer #(
    parameter int DATA_W     = 12,
    parameter int DEPTH_LOG2 = 4,
    parameter int DIV_W      = 16
) (
    input  logic                  clk_50M,
    input  logic                  rst,
    input  logic                  enable,
    input  logic [DIV_W-1:0]      period,
    dac_sample_pacer_if.slave     bus,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  underrun,
    output logic                  late
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_LEVEL = {1'b1, {DEPTH_LOG2{1'b0}}};

    // Sample storage, written on push and read through the dac_data register.
    logic [DATA_W-1:0] mem [DEPTH];

    logic [DIV_W-1:0]      cnt_reg,      cnt_next;
    logic [DEPTH_LOG2-1:0] wr_ptr_reg,   wr_ptr_next;
    logic [DEPTH_LOG2-1:0] rd_ptr_reg,   rd_ptr_next;
    logic [DEPTH_LOG2:0]   level_reg,    level_next;
    logic                  start_reg,    start_next;
    logic                  underrun_reg, underrun_next;
    logic                  late_reg,     late_next;
    logic [DATA_W-1:0]     dac_data_reg;

    logic [DIV_W-1:0] period_eff;
    logic [DIV_W-1:0] reload_val;
    logic             tick;
    logic             empty;
    logic             full;
    logic             push;
    logic             pop;

    // Periods of 0 or 1 are clamped so that dac_start can never fire on
    // consecutive cycles.
    assign period_eff = (period < DIV_W'(2)) ? DIV_W'(2) : period;
    assign reload_val = period_eff - DIV_W'(1);

    assign tick  = enable && (cnt_reg == '0);
    assign empty = (level_reg == '0);
    assign full  = (level_reg == FULL_LEVEL);

    // Both decisions use the registered occupancy, so a push landing on a tick
    // cycle is not visible to that tick's pop.
    assign push = bus.in_valid && !full;
    assign pop  = tick && !empty && !bus.dac_busy;

    always_comb begin
        cnt_next      = cnt_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        level_next    = level_reg;
        start_next    = 1'b0;
        underrun_next = underrun_reg;
        late_next     = late_reg;

        // Held at the reload value while disabled, so the first tick lands
        // period_eff cycles after enable rises; period is only sampled here.
        if (!enable || tick) begin
            cnt_next = reload_val;
        end else begin
            cnt_next = cnt_reg - DIV_W'(1);
        end

        if (push) begin
            wr_ptr_next = wr_ptr_reg + DEPTH_LOG2'(1);
        end
        if (pop) begin
            rd_ptr_next = rd_ptr_reg + DEPTH_LOG2'(1);
        end

        case ({push, pop})
            2'b10:   level_next = level_reg + (DEPTH_LOG2+1)'(1);
            2'b01:   level_next = level_reg - (DEPTH_LOG2+1)'(1);
            default: level_next = level_reg;
        endcase

        if (tick && empty) begin
            underrun_next = 1'b1;
        end
        if (tick && bus.dac_busy) begin
            late_next = 1'b1;
        end

`ifdef DAC_PACER_HOLD_REFRESH_EN
        // Empty FIFO: repeat the last word so the DAC keeps being refreshed.
        start_next = pop || (tick && empty && !bus.dac_busy);
`else
        start_next = pop;
`endif
    end

    always_ff @(posedge clk_50M) begin
        if (rst) begin
            cnt_reg      <= reload_val;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            level_reg    <= '0;
            start_reg    <= 1'b0;
            underrun_reg <= 1'b0;
            late_reg     <= 1'b0;
        end else begin
            cnt_reg      <= cnt_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            level_reg    <= level_next;
            start_reg    <= start_next;
            underrun_reg <= underrun_next;
            late_reg     <= late_next;
        end
    end

    // Storage array carries no reset so it maps onto block RAM.
    always_ff @(posedge clk_50M) begin
        if (push) begin
            mem[wr_ptr_reg] <= bus.in_data;
        end
    end

    // Registered read port doubles as the held output word.
    always_ff @(posedge clk_50M) begin
        if (rst) begin
            dac_data_reg <= '0;
        end else if (pop) begin
            dac_data_reg <= mem[rd_ptr_reg];
        end
    end

    assign bus.in_ready  = !full;
    assign bus.dac_data  = dac_data_reg;
    assign bus.dac_start = start_reg;
    assign level         = level_reg;
    assign underrun      = underrun_reg;
    assign late          = late_reg;

endmodule
